// File: rtl/fp_div_pkg.sv
// Shared encodings for the iterative floating-point divider: FSM state codes and
// bit positions inside the exception flag vector.
package fp_div_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_UNPACK = 3'd1;
  localparam state_t ST_DIV    = 3'd2;
  localparam state_t ST_NORM   = 3'd3;
  localparam state_t ST_ROUND  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam int unsigned NUM_FLAGS      = 5;
  localparam int unsigned FLAG_INVALID   = 4;
  localparam int unsigned FLAG_DIV_ZERO  = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for fp_div_iter; master is the requester side.
interface fp_div_iter_if
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         num1;
  logic [W-1:0]         num2;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         result;
  logic [MAN_W+1:0]     remainder;
  logic [NUM_FLAGS-1:0] flags;

  modport master (
    output in_valid, num1, num2, out_ready,
    input  in_ready, out_valid, result, remainder, flags
  );

  modport slave (
    input  in_valid, num1, num2, out_ready,
    output in_ready, out_valid, result, remainder, flags
  );

endinterface

// File: rtl/fp_div_round.sv
// Round-to-nearest-even of a normalised quotient, with overflow to infinity and
// flush-to-zero on underflow.
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                       sign,
  input  logic signed [EXP_W+1:0]    exp_in,
  input  logic [MAN_W:0]             mant,
  input  logic                       guard,
  input  logic                       sticky,
  output logic [EXP_W+MAN_W:0]       result,
  output logic [NUM_FLAGS-1:0]       flags
);

  localparam logic signed [EXP_W+1:0] EXP_MAX = $signed({2'b00, {EXP_W{1'b1}}});

  logic                    round_up;
  logic [MAN_W+1:0]        sum;
  logic [MAN_W-1:0]        frac_r;
  logic signed [EXP_W+1:0] exp_r;

  always_comb begin
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    // A carry out of the mantissa means 10.00..0: renormalise by one place.
    frac_r   = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_r    = exp_in + $signed({{(EXP_W+1){1'b0}}, sum[MAN_W+1]});

    result = '0;
    flags  = '0;
    if (exp_r >= EXP_MAX) begin
      result                 = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW]   = 1'b1;
      flags[FLAG_INEXACT]    = 1'b1;
    end else if (exp_r[EXP_W+1] || exp_r == '0) begin
      result                 = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLAG_UNDERFLOW]  = 1'b1;
      flags[FLAG_INEXACT]    = 1'b1;
    end else begin
      result                 = {sign, exp_r[EXP_W-1:0], frac_r};
      flags[FLAG_INEXACT]    = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: restoring mantissa division one quotient bit per cycle,
// subnormals flushed to zero, round-to-nearest-even.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic          clk,
  input  logic          rstn,
  fp_div_iter_if.slave  bus
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned CNT_W = $clog2(MAN_W + 3);
  localparam logic signed [EXP_W+1:0] BIAS    = $signed({3'b000, {(EXP_W-1){1'b1}}});
  localparam logic signed [EXP_W+1:0] EXP_ONE = $signed({{(EXP_W+1){1'b0}}, 1'b1});
  localparam logic [CNT_W-1:0]        CNT_TOP = CNT_W'(MAN_W + 2);

  state_t                  state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic [MAN_W:0]          mb_q, mb_d;
  logic [MAN_W+1:0]        rem_q, rem_d;
  logic [MAN_W+2:0]        quo_q, quo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic                    spec_q, spec_d;
  logic [W-1:0]            res_q, res_d;
  logic [NUM_FLAGS-1:0]    flags_q, flags_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic [MAN_W+1:0] trial;
  logic             ge;
  logic [W-1:0]     rnd_result;
  logic [NUM_FLAGS-1:0] rnd_flags;

  always_comb begin
    ea     = a_q[W-2:MAN_W];
    eb     = b_q[W-2:MAN_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    sgn    = a_q[W-1] ^ b_q[W-1];
    // Zero exponent covers both true zeros and flushed subnormals.
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
  end

  // One restoring step; the first step compares the unshifted dividend.
  always_comb begin
    trial = (cnt_q == CNT_TOP) ? rem_q : {rem_q[MAN_W:0], 1'b0};
    ge    = (trial >= {1'b0, mb_q});
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    spec_d   = spec_q;
    res_d    = res_q;
    flags_d  = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.num1;
          b_d     = bus.num2;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d  = sgn;
        exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
        mb_d    = {1'b1, fb};
        rem_d   = {2'b01, fa};
        quo_d   = '0;
        cnt_d   = CNT_TOP;
        spec_d  = 1'b1;
        flags_d = '0;
        state_d = ST_ROUND;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d                 = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          flags_d[FLAG_INVALID] = 1'b1;
        end else if (a_inf) begin
          res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
          res_d                  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d[FLAG_DIV_ZERO] = 1'b1;
        end else if (b_inf || a_zero) begin
          res_d = {sgn, {(W-1){1'b0}}};
        end else begin
          spec_d  = 1'b0;
          state_d = ST_DIV;
        end
        // Specials skip DIV/NORM; ROUND then acts only as the output register stage.
        if (spec_d) rem_d = '0;
      end
      ST_DIV: begin
        rem_d = ge ? (trial - {1'b0, mb_q}) : trial;
        quo_d = {quo_q[MAN_W+1:0], ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_NORM;
      end
      ST_NORM: begin
        sticky_d = (|rem_q) | (quo_q[MAN_W+2] & quo_q[0]);
        if (!quo_q[MAN_W+2]) begin
          quo_d = {quo_q[MAN_W+1:0], 1'b0};
          exp_d = exp_q - EXP_ONE;
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (!spec_q) begin
          res_d   = rnd_result;
          flags_d = rnd_flags;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      spec_q   <= 1'b0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      spec_q   <= spec_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
    end
  end

  fp_div_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign   (sign_q),
    .exp_in (exp_q),
    .mant   (quo_q[MAN_W+2:2]),
    .guard  (quo_q[1]),
    .sticky (sticky_q),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = res_q;
  assign bus.remainder = rem_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: single and half precision instances, specials,
// rounding, overflow/underflow, backpressure and mid-operation reset.
module tb_fp_div_iter;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  fp_div_iter_if #(.EXP_W(8), .MAN_W(23)) f ();
  fp_div_iter_if #(.EXP_W(5), .MAN_W(10)) h ();

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut_f (.clk(clk), .rstn(rstn), .bus(f));
  fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rstn(rstn), .bus(h));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, wait (bounded) for out_valid, count edges after the accept edge.
  task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [31:0] flg,
                       output logic [31:0] rem, output int lat);
    @(posedge clk); #1;
    if (sel) begin h.in_valid = 1'b1; h.num1 = a[15:0]; h.num2 = b[15:0]; end
    else     begin f.in_valid = 1'b1; f.num1 = a;       f.num2 = b;       end
    @(posedge clk); #1;
    if (sel) begin h.in_valid = 1'b0; h.num1 = ~a[15:0]; h.num2 = ~b[15:0]; end
    else     begin f.in_valid = 1'b0; f.num1 = ~a;       f.num2 = ~b;       end
    lat = 0;
    while (!(sel ? h.out_valid : f.out_valid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = sel ? {16'h0, h.result} : f.result;
    flg = sel ? 32'(h.flags) : 32'(f.flags);
    rem = sel ? 32'(h.remainder) : 32'(f.remainder);
  endtask

  task automatic release_out(input bit sel);
    if (sel) h.out_ready = 1'b1; else f.out_ready = 1'b1;
    @(posedge clk); #1;
    if (sel) h.out_ready = 1'b0; else f.out_ready = 1'b0;
  endtask

  logic [31:0] res, flg, rem, r0;
  int          lat;
  bit          changed;

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    f.in_valid = 1'b0; f.num1 = '0; f.num2 = '0; f.out_ready = 1'b0;
    h.in_valid = 1'b0; h.num1 = '0; h.num2 = '0; h.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", f.result, 32'h0);
    check("rst_flags", 32'(f.flags), 32'h0);
    check("rst_rem", 32'(f.remainder), 32'h0);
    check("rst_out_valid", 32'(f.out_valid), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(f.in_ready), 32'h1);
    check("rst_in_ready_h", 32'(h.in_ready), 32'h1);

    do_op(1'b0, 32'h40C00000, 32'h40400000, res, flg, rem, lat);
    check("6/3_res", res, 32'h40000000);
    check("6/3_flags", flg, 32'h0);
    check("6/3_rem", rem, 32'h0);
    check("6/3_lat", 32'(lat), 32'd29);
    release_out(1'b0);

    do_op(1'b0, 32'h3F800000, 32'h40400000, res, flg, rem, lat);
    check("1/3_res", res, 32'h3EAAAAAB);
    check("1/3_flags", flg, 32'h01);
    release_out(1'b0);

    do_op(1'b0, 32'h3F800000, 32'h00000000, res, flg, rem, lat);
    check("1/0_res", res, 32'h7F800000);
    check("1/0_flags", flg, 32'h08);
    check("1/0_rem", rem, 32'h0);
    check("1/0_lat", 32'(lat), 32'd2);
    release_out(1'b0);

    do_op(1'b0, 32'h00000000, 32'h00000000, res, flg, rem, lat);
    check("0/0_res", res, 32'h7FC00000);
    check("0/0_flags", flg, 32'h10);
    release_out(1'b0);

    do_op(1'b0, 32'h7F7FFFFF, 32'h3F000000, res, flg, rem, lat);
    check("ovf_res", res, 32'h7F800000);
    check("ovf_flags", flg, 32'h05);
    release_out(1'b0);

    do_op(1'b0, 32'h00800000, 32'h7F000000, res, flg, rem, lat);
    check("unf_res", res, 32'h00000000);
    check("unf_flags", flg, 32'h03);
    release_out(1'b0);

    do_op(1'b0, 32'hC0C00000, 32'h40400000, res, flg, rem, lat);
    check("neg_res", res, 32'hC0000000);
    check("neg_flags", flg, 32'h0);
    release_out(1'b0);

    do_op(1'b0, 32'h7FC00001, 32'h3F800000, res, flg, rem, lat);
    check("nan_res", res, 32'h7FC00000);
    check("nan_flags", flg, 32'h10);
    release_out(1'b0);

    do_op(1'b0, 32'h7F800000, 32'h40000000, res, flg, rem, lat);
    check("inf/2_res", res, 32'h7F800000);
    check("inf/2_flags", flg, 32'h0);
    release_out(1'b0);

    do_op(1'b0, 32'h40A00000, 32'hFF800000, res, flg, rem, lat);
    check("5/-inf_res", res, 32'h80000000);
    check("5/-inf_flags", flg, 32'h0);
    release_out(1'b0);

    do_op(1'b0, 32'h7F800000, 32'hFF800000, res, flg, rem, lat);
    check("inf/inf_res", res, 32'h7FC00000);
    check("inf/inf_flags", flg, 32'h10);
    release_out(1'b0);

    do_op(1'b0, 32'h80000001, 32'h3F800000, res, flg, rem, lat);
    check("subn_res", res, 32'h80000000);
    check("subn_flags", flg, 32'h0);
    release_out(1'b0);

    // Backpressure: hold the result, offer a new operand that must not be taken.
    do_op(1'b0, 32'h3F800000, 32'h40400000, res, flg, rem, lat);
    r0 = f.result;
    changed = 1'b0;
    f.in_valid = 1'b1; f.num1 = 32'h40C00000; f.num2 = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (f.result !== r0 || f.out_valid !== 1'b1 || f.flags !== 5'h01) changed = 1'b1;
    end
    check("hold_stable", 32'(changed), 32'h0);
    check("hold_res", f.result, 32'h3EAAAAAB);
    check("hold_in_ready", 32'(f.in_ready), 32'h0);
    release_out(1'b0);
    f.in_valid = 1'b0;
    check("rel_in_ready", 32'(f.in_ready), 32'h1);
    check("rel_out_valid", 32'(f.out_valid), 32'h0);
    @(posedge clk); #1;
    check("no_b2b_accept", 32'(f.in_ready), 32'h1);

    // Abort in the middle of DIV.
    f.in_valid = 1'b1; f.num1 = 32'h40C00000; f.num2 = 32'h40400000;
    @(posedge clk); #1;
    f.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 32'(f.in_ready), 32'h0);
    rstn = 1'b0;
    #1;
    check("abort_result", f.result, 32'h0);
    check("abort_flags", 32'(f.flags), 32'h0);
    check("abort_rem", 32'(f.remainder), 32'h0);
    check("abort_out_valid", 32'(f.out_valid), 32'h0);
    check("abort_in_ready", 32'(f.in_ready), 32'h1);
    @(posedge clk); #1;
    rstn = 1'b1;
    do_op(1'b0, 32'h40C00000, 32'h40400000, res, flg, rem, lat);
    check("post_rst_res", res, 32'h40000000);
    check("post_rst_lat", 32'(lat), 32'd29);
    release_out(1'b0);

    do_op(1'b1, 32'h00003C00, 32'h00004200, res, flg, rem, lat);
    check("half_res", res, 32'h00003555);
    check("half_flags", flg, 32'h01);
    check("half_lat", 32'(lat), 32'd16);
    release_out(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
